spectrum_integrator: RTL and testbench

//  Downstream of the two-channel data combiner. Consumes its serialized 16-bit power stream:
//  2*FFT_POINT bins per frame, with bin index. Integrates ACC_NUM consecutive frames bin-by-bin
//  in an internal inferred RAM and emits one integrated frame. Reduces the data rate by
//  ACC_NUM before the packetizer.

---
 rtl/spectrum_integrator.sv | 175 +++++++++++++++++
 tb/tb_spectrum_integrator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_integrator.sv
// spectrum_integrator
//   Integrates ACC_NUM consecutive power frames bin-by-bin and emits one
//   integrated frame, cutting the data rate by ACC_NUM ahead of the packetizer.
//   Input is a serialized stream of FRAME_LEN = 2*FFT_POINT bins with bin index.
//   Running sums live in an inferred RAM indexed by bin.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   din_valid    input sample valid
//   din_bin      bin index of din (BIN_W bits)
//   din          16-bit unsigned power sample
//   dout_valid   integrated sample valid (only during the last integrated frame)
//   dout_bin     bin index of dout
//   dout         saturated integrated sum (ACC_W bits)
//   dout_last    marks bin FRAME_LEN-1 of the integrated frame
//   frame_cnt    frames completed in the current integration, 0..ACC_NUM-1
//   ovf          sticky saturation flag, cleared only by rst
//   sync_err     one-cycle pulse on a bin-sequence violation
module spectrum_integrator #(
  parameter int FFT_POINT = 512,
  parameter int BIN_W     = 10,
  parameter int ACC_NUM   = 16,
  parameter int ACC_W     = 32,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [BIN_W-1:0]  din_bin,
  input  logic [15:0]       din,
  output logic              dout_valid,
  output logic [BIN_W-1:0]  dout_bin,
  output logic [ACC_W-1:0]  dout,
  output logic              dout_last,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              ovf,
  output logic              sync_err
);

  localparam int                FRAME_LEN  = 2 * FFT_POINT;
  localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(FRAME_LEN - 1);
  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(ACC_NUM - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic [BIN_W-1:0] exp_bin;

  logic [ACC_W-1:0] ram [FRAME_LEN];
  logic [ACC_W-1:0] ram_q;

  // Stage 1: sample accepted last cycle, RAM read data arriving in ram_q
  logic             s1_valid;
  logic [BIN_W-1:0] s1_bin;
  logic [15:0]      s1_din;
  logic             s1_first;
  logic             s1_out;

  // Stage 2: registered sum waiting to be written back
  logic             s2_we;
  logic [BIN_W-1:0] s2_bin;
  logic [ACC_W-1:0] s2_sum;

  logic              accept;
  logic              mismatch;
  logic [FCNT_W-1:0] idx;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] prev;
  logic [ACC_W-1:0] sum_sat;
  logic             sat;

  // Accept/mismatch decision. A bin-0 sample that breaks the sequence
  // restarts the integration in the same cycle, so idx is forced to 0.
  always_comb begin
    accept   = 1'b0;
    mismatch = 1'b0;
    idx      = frame_cnt;
    if (din_valid) begin
      if (state == ACC && din_bin == exp_bin) begin
        accept = 1'b1;
      end else begin
        if (state == ACC) mismatch = 1'b1;
        if (din_bin == '0) begin
          accept = 1'b1;
          idx    = '0;
        end
      end
    end
  end

  // Sequencing FSM: tracks the expected bin and the frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      exp_bin   <= '0;
      frame_cnt <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= mismatch;
      if (accept) begin
        state <= ACC;
        if (din_bin == LAST_BIN) begin
          exp_bin   <= '0;
          frame_cnt <= (idx == LAST_FRAME) ? '0 : idx + FCNT_W'(1);
        end else begin
          exp_bin   <= din_bin + BIN_W'(1);
          frame_cnt <= idx;
        end
      end else if (mismatch) begin
        state     <= IDLE;
        frame_cnt <= '0;
      end
    end
  end

  // Accumulator RAM: read at acceptance, write back two cycles later.
  // Same-bin accesses are at least FRAME_LEN cycles apart, so no bypass.
  always_ff @(posedge clk) begin
    if (accept) ram_q <= ram[din_bin];
    if (s2_we) ram[s2_bin] <= s2_sum;
  end

  // Stage 1 register. Frame 0 ignores the RAM contents so stale data
  // left from an earlier integration or a reset never enters a sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_din   <= '0;
      s1_first <= 1'b0;
      s1_out   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_bin   <= din_bin;
      s1_din   <= din;
      s1_first <= (idx == '0);
      s1_out   <= (idx == LAST_FRAME);
    end
  end

  // Sum one bit wider than the accumulator so overflow can be detected.
  always_comb begin
    prev     = s1_first ? '0 : ram_q;
    sum_wide = {1'b0, prev} + {{(ACC_W-15){1'b0}}, s1_din};
    sat      = sum_wide[ACC_W];
    sum_sat  = sat ? '1 : sum_wide[ACC_W-1:0];
  end

  // Stage 2: registered sum for write-back, output registers, sticky ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_we      <= 1'b0;
      s2_bin     <= '0;
      s2_sum     <= '0;
      dout_valid <= 1'b0;
      dout_bin   <= '0;
      dout       <= '0;
      dout_last  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s2_we      <= s1_valid;
      s2_bin     <= s1_bin;
      s2_sum     <= sum_sat;
      dout_valid <= s1_valid && s1_out;
      dout_last  <= s1_valid && s1_out && (s1_bin == LAST_BIN);
      if (s1_valid && s1_out) begin
        dout     <= sum_sat;
        dout_bin <= s1_bin;
      end
      if (s1_valid && sat) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spectrum_integrator.sv
// tb_spectrum_integrator
//   Directed self-checking bench for spectrum_integrator with FFT_POINT=8
//   (16 bins), ACC_NUM=4, ACC_W=17. Each scenario task drives its own
//   stimulus and checks the observed outputs against hand-computed sums.
module tb_spectrum_integrator;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [3:0]  din_bin;
  logic [15:0] din;
  logic        dout_valid;
  logic [3:0]  dout_bin;
  logic [16:0] dout;
  logic        dout_last;
  logic [2:0]  frame_cnt;
  logic        ovf;
  logic        sync_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int err_pulses = 0;

  int in_cyc[$];
  int out_cyc[$];
  int out_bin[$];
  int out_data[$];
  int out_last[$];

  spectrum_integrator #(
    .FFT_POINT(8),
    .BIN_W(4),
    .ACC_NUM(4),
    .ACC_W(17),
    .FCNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_valid(din_valid),
    .din_bin(din_bin),
    .din(din),
    .dout_valid(dout_valid),
    .dout_bin(dout_bin),
    .dout(dout),
    .dout_last(dout_last),
    .frame_cnt(frame_cnt),
    .ovf(ovf),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (dout_valid) begin
      out_cyc.push_back(cyc);
      out_bin.push_back(int'(dout_bin));
      out_data.push_back(int'(dout));
      out_last.push_back(int'(dout_last));
    end
    if (sync_err) err_pulses++;
  end

  function automatic int model_data(input int mode, input int bin);
    if (mode == 0) return bin + 1;
    if (mode == 1) return 'hFFFF;
    return 3 * bin + 7;
  endfunction

  function automatic int exp_sum(input int mode, input int bin);
    int s;
    s = 4 * model_data(mode, bin);
    if (s > 'h1FFFF) s = 'h1FFFF;
    return s;
  endfunction

  task automatic clear_logs();
    in_cyc.delete();
    out_cyc.delete();
    out_bin.delete();
    out_data.delete();
    out_last.delete();
    err_pulses = 0;
  endtask

  task automatic drive(input logic v, input int bin, input int data);
    @(negedge clk);
    din_valid = v;
    din_bin   = 4'(bin);
    din       = 16'(data);
    if (v) in_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic send_frame(input int first_bin, input int last_bin, input int skip_bin,
                            input int mode, input int max_gap);
    for (int b = first_bin; b <= last_bin; b++) begin
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      if (b != skip_bin) drive(1'b1, b, model_data(mode, b));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    din_bin = '0;
    din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_valid: got %0b expected 0", dout_valid); end
    checks++;
    if (dout !== 17'd0) begin errors++; $display("[TB] FAIL reset_dout: got %0h expected 0", dout); end
    checks++;
    if (dout_bin !== 4'd0) begin errors++; $display("[TB] FAIL reset_dout_bin: got %0d expected 0", dout_bin); end
    checks++;
    if (dout_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_last: got %0b expected 0", dout_last); end
    checks++;
    if (frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_err: got %0b expected 0", sync_err); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_logs();
    repeat (4) send_frame(0, 15, -1, 0, 0);
    idle(4);
    n = in_cyc.size();
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== exp_sum(0, i) || out_last[i] !== int'(i == 15)) begin
        errors++;
        $display("[TB] FAIL b2b_out[%0d]: got bin %0d data %0h last %0d expected bin %0d data %0h last %0d",
                 i, out_bin[i], out_data[i], out_last[i], i, exp_sum(0, i), int'(i == 15));
      end
      checks++;
      if (out_cyc[i] - in_cyc[n-16+i] !== 2) begin
        errors++;
        $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 2", i, out_cyc[i] - in_cyc[n-16+i]);
      end
    end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("[TB] FAIL b2b_sync_err: got %0d expected 0", err_pulses); end
  endtask

  task automatic test_gaps();
    int n;
    clear_logs();
    for (int f = 0; f < 4; f++) begin
      send_frame(0, 15, -1, 0, 3);
      idle(1);
      checks++;
      if (frame_cnt !== 3'((f + 1) % 4)) begin
        errors++;
        $display("[TB] FAIL gaps_frame_cnt[%0d]: got %0d expected %0d", f, frame_cnt, (f + 1) % 4);
      end
    end
    idle(4);
    n = in_cyc.size();
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL gaps_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== exp_sum(0, i) || out_last[i] !== int'(i == 15)) begin
        errors++;
        $display("[TB] FAIL gaps_out[%0d]: got bin %0d data %0h last %0d expected bin %0d data %0h last %0d",
                 i, out_bin[i], out_data[i], out_last[i], i, exp_sum(0, i), int'(i == 15));
      end
      checks++;
      if (out_cyc[i] - in_cyc[n-16+i] !== 2) begin
        errors++;
        $display("[TB] FAIL gaps_latency[%0d]: got %0d expected 2", i, out_cyc[i] - in_cyc[n-16+i]);
      end
    end
  endtask

  task automatic test_mismatch();
    int n;
    clear_logs();
    send_frame(0, 15, -1, 0, 0);
    send_frame(0, 15, -1, 0, 0);
    send_frame(0, 15, 5, 0, 0);
    idle(2);
    checks++;
    if (err_pulses !== 1) begin errors++; $display("[TB] FAIL mis_pulses: got %0d expected 1", err_pulses); end
    checks++;
    if (frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL mis_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++;
    if (out_data.size() !== 0) begin errors++; $display("[TB] FAIL mis_no_dout: got %0d expected 0", out_data.size()); end
    repeat (4) send_frame(0, 15, -1, 0, 0);
    idle(4);
    n = in_cyc.size();
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL mis_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== exp_sum(0, i) || out_last[i] !== int'(i == 15)
          || out_cyc[i] - in_cyc[n-16+i] !== 2) begin
        errors++;
        $display("[TB] FAIL mis_out[%0d]: got bin %0d data %0h last %0d lat %0d expected bin %0d data %0h last %0d lat 2",
                 i, out_bin[i], out_data[i], out_last[i], out_cyc[i] - in_cyc[n-16+i], i, exp_sum(0, i), int'(i == 15));
      end
    end
    checks++;
    if (err_pulses !== 1) begin errors++; $display("[TB] FAIL mis_pulses_end: got %0d expected 1", err_pulses); end
  endtask

  task automatic test_late_start();
    int n;
    pulse_reset();
    clear_logs();
    send_frame(7, 15, -1, 0, 0);
    idle(2);
    checks++;
    if (frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL late_frame_cnt: got %0d expected 0", frame_cnt); end
    repeat (3) send_frame(0, 15, -1, 0, 0);
    idle(4);
    checks++;
    if (out_data.size() !== 0) begin errors++; $display("[TB] FAIL late_early_dout: got %0d expected 0", out_data.size()); end
    send_frame(0, 15, -1, 0, 0);
    idle(4);
    n = in_cyc.size();
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL late_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== exp_sum(0, i) || out_last[i] !== int'(i == 15)
          || out_cyc[i] - in_cyc[n-16+i] !== 2) begin
        errors++;
        $display("[TB] FAIL late_out[%0d]: got bin %0d data %0h last %0d lat %0d expected bin %0d data %0h last %0d lat 2",
                 i, out_bin[i], out_data[i], out_last[i], out_cyc[i] - in_cyc[n-16+i], i, exp_sum(0, i), int'(i == 15));
      end
    end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("[TB] FAIL late_sync_err: got %0d expected 0", err_pulses); end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_logs();
    repeat (3) send_frame(0, 15, -1, 0, 0);
    send_frame(0, 9, -1, 0, 0);
    pulse_reset();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 17'd0 || dout_bin !== 4'd0 || dout_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mrst_outputs: got valid %0b dout %0h bin %0d last %0b expected all 0",
               dout_valid, dout, dout_bin, dout_last);
    end
    checks++;
    if (frame_cnt !== 3'd0 || ovf !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mrst_status: got frame_cnt %0d ovf %0b sync_err %0b expected all 0", frame_cnt, ovf, sync_err);
    end
    clear_logs();
    idle(4);
    checks++;
    if (out_data.size() !== 0) begin errors++; $display("[TB] FAIL mrst_flush: got %0d expected 0", out_data.size()); end
    repeat (4) send_frame(0, 15, -1, 2, 0);
    idle(4);
    n = in_cyc.size();
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL mrst_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== exp_sum(2, i) || out_last[i] !== int'(i == 15)
          || out_cyc[i] - in_cyc[n-16+i] !== 2) begin
        errors++;
        $display("[TB] FAIL mrst_out[%0d]: got bin %0d data %0h last %0d lat %0d expected bin %0d data %0h last %0d lat 2",
                 i, out_bin[i], out_data[i], out_last[i], out_cyc[i] - in_cyc[n-16+i], i, exp_sum(2, i), int'(i == 15));
      end
    end
  endtask

  task automatic test_saturation();
    logic exp_ovf;
    pulse_reset();
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      send_frame(0, 15, -1, 1, 0);
      idle(1);
      exp_ovf = (f == 2);
      checks++;
      if (ovf !== exp_ovf) begin errors++; $display("[TB] FAIL sat_ovf_frame[%0d]: got %0b expected %0b", f, ovf, exp_ovf); end
    end
    send_frame(0, 15, -1, 1, 0);
    idle(4);
    checks++;
    if (out_data.size() !== 16) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 16", out_data.size()); end
    for (int i = 0; i < 16 && i < out_data.size(); i++) begin
      checks++;
      if (out_bin[i] !== i || out_data[i] !== 'h1FFFF || out_last[i] !== int'(i == 15)) begin
        errors++;
        $display("[TB] FAIL sat_out[%0d]: got bin %0d data %0h last %0d expected bin %0d data 1ffff last %0d",
                 i, out_bin[i], out_data[i], out_last[i], i, int'(i == 15));
      end
    end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf_sticky: got %0b expected 1", ovf); end
    pulse_reset();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL sat_ovf_cleared: got %0b expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_mismatch();
    test_late_start();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
